// File: rtl/mul_datapath_if.sv
// Handshake/data bundle between the multiplier control FSM (master) and its datapath (slave).
interface mul_datapath_if #(
    parameter int W  = 16,
    parameter int PW = 16
);
    logic [W-1:0]  data_in;
    logic          ldA;
    logic          ldB;
    logic          ldP;
    logic          clrP;
    logic          decB;
    logic          eqz;
    logic [PW-1:0] product;
    logic [W-1:0]  iter_cnt;
    logic          ovf;

    modport master (
        output data_in, ldA, ldB, ldP, clrP, decB,
        input  eqz, product, iter_cnt, ovf
    );

    modport slave (
        input  data_in, ldA, ldB, ldP, clrP, decB,
        output eqz, product, iter_cnt, ovf
    );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: registers A, down-counting B, accumulator P, iteration count.
// Define MUL_OVF_DETECT_EN to build the sticky carry-out overflow flag; otherwise ovf is tied low.
module mul_datapath #(
    parameter int W  = 16,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_datapath_if.slave bus
);
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0] p_q, p_d;
    logic          b_nz;
    logic          add_en;

    assign b_nz   = (b_q != '0);
    // Gating on the pre-edge B absorbs the control's one-cycle lag on eqz.
    assign add_en = bus.ldP && !bus.clrP && b_nz;

    always_comb begin
        a_d = a_q;
        if (bus.ldA) a_d = bus.data_in;
    end

    always_comb begin
        b_d = b_q;
        if (bus.ldB)              b_d = bus.data_in;
        else if (bus.decB && b_nz) b_d = b_q - 1'b1;
    end

`ifdef MUL_OVF_DETECT_EN
    logic [PW:0] sum_ext;
    logic        ovf_q, ovf_d;

    assign sum_ext = {1'b0, p_q} + (PW + 1)'(a_q);

    always_comb begin
        p_d   = p_q;
        ovf_d = ovf_q;
        if (bus.clrP) begin
            p_d   = '0;
            ovf_d = 1'b0;
        end else if (add_en) begin
            p_d   = sum_ext[PW-1:0];
            ovf_d = ovf_q | sum_ext[PW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`else
    always_comb begin
        p_d = p_q;
        if (bus.clrP)    p_d = '0;
        else if (add_en) p_d = p_q + PW'(a_q);
    end

    assign bus.ovf = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clrP)                    cnt_d = '0;
        else if (add_en && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.eqz      = !b_nz;
    assign bus.product  = p_q;
    assign bus.iter_cnt = cnt_q;
endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: vector table, directed corner sequences, random multiplies.
module tb_mul_datapath;
    localparam int W  = 16;
    localparam int PW = 16;
`ifdef MUL_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mul_datapath_if #(.W(W), .PW(PW)) bus_if ();

    mul_datapath #(.W(W), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          extra;
        logic [15:0] exp_p;
        logic [15:0] exp_iter;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.ldA  = 1'b0;
        bus_if.ldB  = 1'b0;
        bus_if.ldP  = 1'b0;
        bus_if.clrP = 1'b0;
        bus_if.decB = 1'b0;
    endtask

    // Full multiply as the control FSM would sequence it; lat counts edges until eqz.
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input int extra,
                            output int lat, output bit eqz_stuck);
        @(negedge clk);
        idle_inputs();
        bus_if.data_in = a;
        bus_if.ldA     = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.data_in = b;
        bus_if.ldB     = 1'b1;
        bus_if.clrP    = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.ldP  = 1'b1;
        bus_if.decB = 1'b1;
        lat = 0;
        while (!bus_if.eqz && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        eqz_stuck = 1'b1;
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            if (!bus_if.eqz) eqz_stuck = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic check_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input int extra, input logic [15:0] exp_p,
                              input logic [15:0] exp_iter, input bit exp_ovf);
        int lat;
        bit stuck;
        run_mult(a, b, extra, lat, stuck);
        chk({tag, "_latency"}, lat, b);
        chk({tag, "_eqz_hold"}, stuck, 1'b1);
        chk({tag, "_product"}, bus_if.product, exp_p);
        chk({tag, "_iter"}, bus_if.iter_cnt, exp_iter);
        chk({tag, "_ovf"}, bus_if.ovf, exp_ovf);
        $display("%s: A=%0h B=%0d extra=%0d -> P=%0h iter=%0d ovf=%0b lat=%0d",
                 tag, a, b, extra, bus_if.product, bus_if.iter_cnt, bus_if.ovf, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit stuck;
        logic [15:0] ra, rb;
        longint prod;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_if.data_in = '0;
        idle_inputs();

        vecs[0] = '{16'd7,      16'd5,  2, 16'd35,    16'd5,  1'b0};
        vecs[1] = '{16'd0,      16'd6,  0, 16'd0,     16'd6,  1'b0};
        vecs[2] = '{16'd9,      16'd0,  3, 16'd0,     16'd0,  1'b0};
        vecs[3] = '{16'h8000,   16'd3,  0, 16'h8000,  16'd3,  OVF_EN};
        vecs[4] = '{16'hFFFF,   16'd2,  1, 16'hFFFE,  16'd2,  OVF_EN};
        vecs[5] = '{16'd1000,   16'd70, 0, 16'd4464,  16'd70, OVF_EN};

        #12;
        chk("reset_eqz", bus_if.eqz, 1'b1);
        chk("reset_product", bus_if.product, 16'd0);
        chk("reset_iter", bus_if.iter_cnt, 16'd0);
        chk("reset_ovf", bus_if.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            check_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].extra,
                       vecs[i].exp_p, vecs[i].exp_iter, vecs[i].exp_ovf);

        // Overflow flag clears on clrP alone.
        @(negedge clk);
        bus_if.clrP = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("ovf_clr", bus_if.ovf, 1'b0);
        chk("ovf_clr_product", bus_if.product, 16'd0);
        $display("ovf_clear: ovf=%0b P=%0h", bus_if.ovf, bus_if.product);

        // Mid-run asynchronous reset: A=4, B=8, three adds -> P=12, B=5.
        @(negedge clk);
        bus_if.data_in = 16'd4; bus_if.ldA = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.data_in = 16'd8; bus_if.ldB = 1'b1; bus_if.clrP = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.ldP = 1'b1; bus_if.decB = 1'b1;
        repeat (3) @(negedge clk);
        idle_inputs();
        chk("premid_product", bus_if.product, 16'd12);
        chk("premid_eqz", bus_if.eqz, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_eqz", bus_if.eqz, 1'b1);
        chk("midrst_product", bus_if.product, 16'd0);
        chk("midrst_iter", bus_if.iter_cnt, 16'd0);
        chk("midrst_ovf", bus_if.ovf, 1'b0);
        $display("mid_reset: eqz=%0b P=%0h iter=%0d", bus_if.eqz, bus_if.product, bus_if.iter_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        // ldB beats decB on the same edge: B must land at 3, then exactly 3 adds of A=6.
        @(negedge clk);
        bus_if.data_in = 16'd6; bus_if.ldA = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.data_in = 16'd3; bus_if.ldB = 1'b1; bus_if.decB = 1'b1; bus_if.clrP = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.ldP = 1'b1; bus_if.decB = 1'b1;
        lat = 0;
        while (!bus_if.eqz && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        idle_inputs();
        chk("prio_ldb_lat", lat, 3);
        chk("prio_ldb_product", bus_if.product, 16'd18);
        $display("prio_ldB: lat=%0d P=%0d", lat, bus_if.product);

        // clrP beats ldP: P=20 first, reload B=2 without clear, then clrP+ldP together.
        run_mult(16'd4, 16'd5, 0, lat, stuck);
        chk("prio_pre_product", bus_if.product, 16'd20);
        @(negedge clk);
        bus_if.data_in = 16'd2; bus_if.ldB = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.clrP = 1'b1; bus_if.ldP = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("prio_clr_product", bus_if.product, 16'd0);
        chk("prio_clr_iter", bus_if.iter_cnt, 16'd0);
        $display("prio_clrP: P=%0d iter=%0d", bus_if.product, bus_if.iter_cnt);

        // Same-edge ldA with ldP: add uses old A=4, then new A=10.
        @(negedge clk);
        bus_if.data_in = 16'd4; bus_if.ldA = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.data_in = 16'd2; bus_if.ldB = 1'b1; bus_if.clrP = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_if.data_in = 16'd10; bus_if.ldA = 1'b1; bus_if.ldP = 1'b1; bus_if.decB = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("ldA_ldP_edge1", bus_if.product, 16'd4);
        bus_if.ldP = 1'b1; bus_if.decB = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("ldA_ldP_edge2", bus_if.product, 16'd14);
        chk("ldA_ldP_eqz", bus_if.eqz, 1'b1);
        $display("ldA_ldP: P=%0d eqz=%0b", bus_if.product, bus_if.eqz);

        // Random multiplies against plain arithmetic.
        for (int i = 0; i < 20; i++) begin
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 12));
            prod = longint'(ra) * longint'(rb);
            check_mult($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 2)),
                       16'(prod % 65536), rb, OVF_EN && (prod >= 65536));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
